// File: rtl/gfx_pkg.sv
// Shared definitions for the draw command path: opcodes, engine indices and
// the dispatcher state encoding.
package gfx_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned NUM_ENG = 3;

  localparam logic [OPC_W-1:0] OP_NOP      = 4'd0;
  localparam logic [OPC_W-1:0] OP_LINE     = 4'd1;
  localparam logic [OPC_W-1:0] OP_CIRCLE   = 4'd2;
  localparam logic [OPC_W-1:0] OP_FILLRECT = 4'd3;
  localparam logic [OPC_W-1:0] OP_SYNC     = 4'd4;

  localparam int unsigned ENG_LINE = 0;
  localparam int unsigned ENG_CIRC = 1;
  localparam int unsigned ENG_FILL = 2;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_SYNC = 1'b1
  } disp_state_e;

  // One-hot engine select for a draw opcode; zero for NOP, SYNC and illegal codes.
  function automatic logic [NUM_ENG-1:0] op_engine(input logic [OPC_W-1:0] op);
    logic [NUM_ENG-1:0] eng;
    eng = '0;
    case (op)
      OP_NOP:      eng = '0;
      OP_LINE:     eng = NUM_ENG'(1) << ENG_LINE;
      OP_CIRCLE:   eng = NUM_ENG'(1) << ENG_CIRC;
      OP_FILLRECT: eng = NUM_ENG'(1) << ENG_FILL;
      default:     eng = '0;
    endcase
    return eng;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: synchronous, power-of-2 depth, pointer-based storage.
// Ports: i_push/i_wdata write side, i_pop read side (both ignored when
// full/empty respectively), o_head_data_c = oldest entry, o_full_c/o_empty_c
// flags from the registered count, o_count = registered occupancy.
module cmd_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [WIDTH-1:0]         o_head_data_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_full_c      = (o_count == CW'(DEPTH));
  assign o_empty_c     = (o_count == '0);
  assign o_head_data_c = r_mem[r_rptr];
  assign w_wr          = i_push & ~o_full_c;
  assign w_rd          = i_pop & ~o_empty_c;

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      o_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/draw_cmd_dispatcher.sv
// Draw command dispatcher: buffers decoded commands and starts the line,
// circle and fill-rect engines strictly in order, tracking outstanding work.
// Ports: cmd_* = command input handshake; eng_start_out/eng_params_out =
// registered engine launch; eng_done_in = engine completion pulses;
// idle_out, err_out (sticky illegal-opcode / spurious-done), disp_count_out.
module draw_cmd_dispatcher
  import gfx_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PARAM_W     = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [OPC_W-1:0]       cmd_opcode,
  input  logic [PARAM_W-1:0]     cmd_params,
  input  logic                   cmd_rts_in,
  output logic                   cmd_rtr_out,
  output logic [NUM_ENGINES-1:0] eng_start_out,
  output logic [PARAM_W-1:0]     eng_params_out,
  input  logic [NUM_ENGINES-1:0] eng_done_in,
  output logic                   idle_out,
  output logic [1:0]             err_out,
  output logic [CNT_W-1:0]       disp_count_out
);

  localparam int unsigned CMD_W  = OPC_W + PARAM_W;
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CMD_W-1:0]       w_head;
  logic [FCNT_W-1:0]      w_fifo_cnt;
  logic [OPC_W-1:0]       w_head_op;
  logic [PARAM_W-1:0]     w_head_params;
  logic [NUM_ENGINES-1:0] w_head_eng;
  logic [NUM_ENGINES-1:0] w_free;
  logic [NUM_ENGINES-1:0] w_out_after_done;
  logic [NUM_ENGINES-1:0] w_start;
  logic                   w_eval;
  logic                   w_sync_clear;
  logic                   w_illegal;
  logic                   w_sync_hold;

  logic [NUM_ENGINES-1:0] r_outstanding;
  logic                   r_fresh;
  disp_state_e            r_state;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_          (rst_),
    .i_push        (w_push),
    .i_wdata       ({cmd_opcode, cmd_params}),
    .i_pop         (w_pop),
    .o_full_c      (w_full),
    .o_empty_c     (w_empty),
    .o_head_data_c (w_head),
    .o_count       (w_fifo_cnt)
  );

  assign cmd_rtr_out = ~w_full;
  assign w_push      = cmd_rts_in & ~w_full;
  assign idle_out    = (w_fifo_cnt == '0) & ~|r_outstanding;

  assign {w_head_op, w_head_params} = w_head;
  assign w_head_eng       = NUM_ENGINES'(op_engine(w_head_op));
  assign w_illegal        = (w_head_op > OP_SYNC);
  assign w_free           = ~r_outstanding | eng_done_in;
  assign w_out_after_done = r_outstanding & ~eng_done_in;
  assign w_sync_clear     = ~|w_out_after_done;

  // A command written on the previous edge sits as head for one cycle before
  // it is evaluated; older entries are evaluated as soon as they reach head.
  assign w_eval = ~w_empty & ~r_fresh;

  // Dispatch decode for the head entry; at most one pop per cycle.
  always_comb begin
    w_pop       = 1'b0;
    w_start     = '0;
    w_sync_hold = 1'b0;
    if (w_eval) begin
      if ((r_state == S_SYNC) || (w_head_op == OP_SYNC)) begin
        w_pop       = w_sync_clear;
        w_sync_hold = ~w_sync_clear;
      end else if (|w_head_eng) begin
        if (|(w_head_eng & w_free)) begin
          w_pop   = 1'b1;
          w_start = w_head_eng;
        end
      end else begin
        // NOP and illegal opcodes are simply retired.
        w_pop = 1'b1;
      end
    end
  end

  // State, outstanding tracking and all registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state        <= S_RUN;
      r_fresh        <= 1'b0;
      r_outstanding  <= '0;
      eng_start_out  <= '0;
      eng_params_out <= '0;
      err_out        <= '0;
      disp_count_out <= '0;
    end else begin
      r_fresh       <= w_push & (w_fifo_cnt == FCNT_W'(w_pop));
      // A start on the same edge as a done keeps the engine marked busy.
      r_outstanding <= w_out_after_done | w_start;
      eng_start_out <= w_start;
      if (|w_start) begin
        eng_params_out <= w_head_params;
        disp_count_out <= disp_count_out + CNT_W'(1);
      end
      if (w_eval & w_illegal & (r_state == S_RUN)) begin
        err_out[0] <= 1'b1;
      end
      if (|(eng_done_in & ~r_outstanding & ~w_start)) begin
        err_out[1] <= 1'b1;
      end
      case (r_state)
        S_RUN:   if (w_sync_hold) r_state <= S_SYNC;
        S_SYNC:  if (w_pop) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_dispatcher.sv
module tb_draw_cmd_dispatcher;

  logic        clk;
  logic        rst_;
  logic [3:0]  cmd_opcode;
  logic [63:0] cmd_params;
  logic        cmd_rts_in;
  logic        cmd_rtr_out;
  logic [2:0]  eng_start_out;
  logic [63:0] eng_params_out;
  logic [2:0]  eng_done_in;
  logic        idle_out;
  logic [1:0]  err_out;
  logic [15:0] disp_count_out;

  int n_chk;
  int n_err;

  draw_cmd_dispatcher dut (
    .clk            (clk),
    .rst_           (rst_),
    .cmd_opcode     (cmd_opcode),
    .cmd_params     (cmd_params),
    .cmd_rts_in     (cmd_rts_in),
    .cmd_rtr_out    (cmd_rtr_out),
    .eng_start_out  (eng_start_out),
    .eng_params_out (eng_params_out),
    .eng_done_in    (eng_done_in),
    .idle_out       (idle_out),
    .err_out        (err_out),
    .disp_count_out (disp_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rts, input logic [3:0] op, input logic [63:0] prm,
                       input logic [2:0] done);
    cmd_rts_in  = rts;
    cmd_opcode  = op;
    cmd_params  = prm;
    eng_done_in = done;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 64'd0, 3'b000);
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // ------------------------------------------------- behavioural reference
  // Commands are kept in a queue stamped with the edge that accepted them; a
  // command may launch no earlier than two edges after acceptance.
  typedef struct {
    logic [3:0]  op;
    logic [63:0] prm;
    int          acc;
  } mcmd_t;

  mcmd_t       mq[$];
  logic [2:0]  m_busy;
  logic [2:0]  m_start;
  logic [63:0] m_params;
  logic [15:0] m_cnt;
  logic [1:0]  m_err;
  int          m_cyc;

  function automatic void model_clear();
    mq.delete();
    m_busy   = 3'b000;
    m_start  = 3'b000;
    m_params = 64'd0;
    m_cnt    = 16'd0;
    m_err    = 2'b00;
    m_cyc    = 0;
  endfunction

  function automatic void model_edge(input logic rts, input logic [3:0] op,
                                     input logic [63:0] prm, input logic [2:0] done);
    bit push;
    bit pop;
    int e;
    push    = rts && (mq.size() < 4);
    pop     = 0;
    m_start = 3'b000;
    if (mq.size() > 0 && mq[0].acc + 2 <= m_cyc) begin
      if (mq[0].op == 4'd0) begin
        pop = 1;
      end else if (mq[0].op <= 4'd3) begin
        e = int'(mq[0].op) - 1;
        if (!m_busy[e] || done[e]) begin
          pop        = 1;
          m_start[e] = 1'b1;
          m_params   = mq[0].prm;
          m_cnt      = m_cnt + 16'd1;
        end
      end else if (mq[0].op == 4'd4) begin
        pop = 1;
        for (int k = 0; k < 3; k++) if (m_busy[k] && !done[k]) pop = 0;
      end else begin
        pop      = 1;
        m_err[0] = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (done[k] && !m_busy[k] && !m_start[k]) m_err[1] = 1'b1;
      m_busy[k] = (m_busy[k] && !done[k]) || m_start[k];
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{op, prm, m_cyc});
    m_cyc++;
  endfunction

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic        rts;
    logic [3:0]  op;
    logic [63:0] prm;
    logic [2:0]  done;
    logic [2:0]  e_start;
    logic [63:0] e_params;
    logic [15:0] e_cnt;
    logic [1:0]  e_err;
    logic        e_idle;
    logic        e_rtr;
  } tv_t;

  function automatic tv_t mk(input logic rts, input logic [3:0] op, input logic [63:0] prm,
                             input logic [2:0] done, input logic [2:0] es,
                             input logic [63:0] ep, input logic [15:0] ec,
                             input logic [1:0] ee, input logic ei, input logic er);
    tv_t t;
    t.rts = rts; t.op = op; t.prm = prm; t.done = done;
    t.e_start = es; t.e_params = ep; t.e_cnt = ec; t.e_err = ee;
    t.e_idle = ei; t.e_rtr = er;
    return t;
  endfunction

  localparam logic [63:0] P1 = 64'h0001_0002_0003_0004;
  localparam logic [63:0] P2 = 64'h0010_0020_0030_0040;
  localparam logic [63:0] P3 = 64'h0100_0200_0300_0400;

  tv_t         tv[21];
  logic [63:0] pq[5];
  logic [63:0] pa;
  int          r;
  logic        rts_r;
  logic [3:0]  op_r;
  logic [63:0] prm_r;
  logic [2:0]  done_r;

  initial begin
    n_chk = 0;
    n_err = 0;
    //          rts  op    prm  done    start   params cnt    err    idle rtr
    tv[0]  = mk(1, 4'd1, P1,   3'b000, 3'b000, 64'd0, 16'd0, 2'b00, 0, 1);
    tv[1]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, 64'd0, 16'd0, 2'b00, 0, 1);
    tv[2]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b001, P1,   16'd1, 2'b00, 0, 1);
    tv[3]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P1,   16'd1, 2'b00, 0, 1);
    tv[4]  = mk(0, 4'd0, 64'd0, 3'b001, 3'b000, P1,   16'd1, 2'b00, 1, 1);
    tv[5]  = mk(1, 4'd1, P2,   3'b000, 3'b000, P1,   16'd1, 2'b00, 0, 1);
    tv[6]  = mk(1, 4'd1, P3,   3'b000, 3'b000, P1,   16'd1, 2'b00, 0, 1);
    tv[7]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b001, P2,   16'd2, 2'b00, 0, 1);
    tv[8]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P2,   16'd2, 2'b00, 0, 1);
    tv[9]  = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P2,   16'd2, 2'b00, 0, 1);
    tv[10] = mk(0, 4'd0, 64'd0, 3'b001, 3'b001, P3,   16'd3, 2'b00, 0, 1);
    tv[11] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b00, 0, 1);
    tv[12] = mk(0, 4'd0, 64'd0, 3'b001, 3'b000, P3,   16'd3, 2'b00, 1, 1);
    tv[13] = mk(1, 4'd7, P1,   3'b000, 3'b000, P3,   16'd3, 2'b00, 0, 1);
    tv[14] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b00, 0, 1);
    tv[15] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b01, 1, 1);
    tv[16] = mk(0, 4'd0, 64'd0, 3'b100, 3'b000, P3,   16'd3, 2'b11, 1, 1);
    tv[17] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b11, 1, 1);
    tv[18] = mk(1, 4'd0, P2,   3'b000, 3'b000, P3,   16'd3, 2'b11, 0, 1);
    tv[19] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b11, 0, 1);
    tv[20] = mk(0, 4'd0, 64'd0, 3'b000, 3'b000, P3,   16'd3, 2'b11, 1, 1);

    // Reset state
    rst_ = 1'b1;
    do_reset();
    chk("reset start",  64'(eng_start_out),  64'd0);
    chk("reset params", eng_params_out,      64'd0);
    chk("reset count",  64'(disp_count_out), 64'd0);
    chk("reset err",    64'(err_out),        64'd0);
    chk("reset idle",   64'(idle_out),       64'd1);
    chk("reset rtr",    64'(cmd_rtr_out),    64'd1);

    // Table: basic launch, in-order hold, done bypass, illegal, spurious done, NOP
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].rts, tv[i].op, tv[i].prm, tv[i].done);
      step();
      chk($sformatf("tv%0d start", i),  64'(eng_start_out),  64'(tv[i].e_start));
      chk($sformatf("tv%0d params", i), eng_params_out,      tv[i].e_params);
      chk($sformatf("tv%0d count", i),  64'(disp_count_out), 64'(tv[i].e_cnt));
      chk($sformatf("tv%0d err", i),    64'(err_out),        64'(tv[i].e_err));
      chk($sformatf("tv%0d idle", i),   64'(idle_out),       64'(tv[i].e_idle));
      chk($sformatf("tv%0d rtr", i),    64'(cmd_rtr_out),    64'(tv[i].e_rtr));
    end

    // SYNC ordering: LINE, CIRCLE, SYNC, FILLRECT
    do_reset();
    drive(1, 4'd1, P1, 3'b000); step();
    chk("sync e0 start", 64'(eng_start_out), 64'd0);
    drive(1, 4'd2, P2, 3'b000); step();
    chk("sync e1 start", 64'(eng_start_out), 64'd0);
    drive(1, 4'd4, 64'd0, 3'b000); step();
    chk("sync e2 start", 64'(eng_start_out), 64'b001);
    drive(1, 4'd3, P3, 3'b000); step();
    chk("sync e3 start", 64'(eng_start_out), 64'b010);
    drive(0, 4'd0, 64'd0, 3'b000); step();
    chk("sync e4 start", 64'(eng_start_out), 64'd0);
    step();
    chk("sync e5 start", 64'(eng_start_out), 64'd0);
    drive(0, 4'd0, 64'd0, 3'b010); step();
    chk("sync done1 start", 64'(eng_start_out), 64'd0);
    drive(0, 4'd0, 64'd0, 3'b001); step();
    chk("sync done0 start", 64'(eng_start_out), 64'd0);
    drive(0, 4'd0, 64'd0, 3'b000); step();
    chk("sync fill start",  64'(eng_start_out), 64'b100);
    chk("sync fill params", eng_params_out,     P3);
    chk("sync fill count",  64'(disp_count_out), 64'd3);
    chk("sync err",         64'(err_out),        64'd0);

    // Full FIFO behind a busy line engine
    do_reset();
    pa = 64'hAAAA_0000_0000_0001;
    for (int j = 0; j < 5; j++) pq[j] = 64'(64'h1111_0000_0000_0000 + 64'(j));
    drive(1, 4'd1, pa, 3'b000); step();
    drive(0, 4'd0, 64'd0, 3'b000); step();
    step();
    chk("full first start", 64'(eng_start_out), 64'b001);
    for (int j = 0; j < 4; j++) begin
      drive(1, 4'd1, pq[j], 3'b000); step();
      chk($sformatf("full acc%0d rtr", j), 64'(cmd_rtr_out), (j == 3) ? 64'd0 : 64'd1);
    end
    drive(1, 4'd1, pq[4], 3'b000); step();
    chk("full held rtr",   64'(cmd_rtr_out),   64'd0);
    chk("full held start", 64'(eng_start_out), 64'd0);
    drive(1, 4'd1, pq[4], 3'b001); step();
    chk("full pop start",  64'(eng_start_out), 64'b001);
    chk("full pop params", eng_params_out,     pq[0]);
    chk("full pop rtr",    64'(cmd_rtr_out),   64'd1);
    drive(1, 4'd1, pq[4], 3'b000); step();
    chk("full refill rtr", 64'(cmd_rtr_out),   64'd0);
    chk("full busy start", 64'(eng_start_out), 64'd0);
    for (int j = 1; j < 5; j++) begin
      drive(0, 4'd0, 64'd0, 3'b001); step();
      chk($sformatf("full drain%0d start", j), 64'(eng_start_out), 64'b001);
      chk($sformatf("full drain%0d params", j), eng_params_out, pq[j]);
    end
    drive(0, 4'd0, 64'd0, 3'b001); step();
    chk("full end idle",  64'(idle_out),       64'd1);
    chk("full end count", 64'(disp_count_out), 64'd6);
    chk("full end err",   64'(err_out),        64'd0);

    // Asynchronous reset while SYNC waits with three entries queued
    do_reset();
    drive(0, 4'd0, 64'd0, 3'b100); step();
    drive(1, 4'd1, P1, 3'b000); step();
    drive(1, 4'd2, P2, 3'b000); step();
    drive(1, 4'd4, 64'd0, 3'b000); step();
    drive(1, 4'd3, P3, 3'b000); step();
    drive(1, 4'd1, P1, 3'b000); step();
    drive(0, 4'd0, 64'd0, 3'b000); step();
    step();
    chk("rst pre count", 64'(disp_count_out), 64'd2);
    chk("rst pre err",   64'(err_out),        64'b10);
    #2;
    rst_ = 1'b0;
    #1;
    chk("rst async start",  64'(eng_start_out),  64'd0);
    chk("rst async params", eng_params_out,      64'd0);
    chk("rst async count",  64'(disp_count_out), 64'd0);
    chk("rst async err",    64'(err_out),        64'd0);
    chk("rst async idle",   64'(idle_out),       64'd1);
    chk("rst async rtr",    64'(cmd_rtr_out),    64'd1);
    #2;
    rst_ = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("rst post%0d start", j), 64'(eng_start_out), 64'd0);
      chk($sformatf("rst post%0d idle", j),  64'(idle_out),      64'd1);
    end

    // Randomized traffic against the reference model
    do_reset();
    model_clear();
    for (int c = 0; c < 500; c++) begin
      rts_r = ($urandom_range(0, 99) < 60);
      r = int'($urandom_range(0, 99));
      if (r < 28)      op_r = 4'd1;
      else if (r < 56) op_r = 4'd2;
      else if (r < 84) op_r = 4'd3;
      else if (r < 90) op_r = 4'd0;
      else if (r < 97) op_r = 4'd4;
      else             op_r = 4'($urandom_range(5, 15));
      prm_r = {$urandom(), $urandom()};
      done_r = 3'b000;
      for (int k = 0; k < 3; k++) begin
        if (m_busy[k]) done_r[k] = ($urandom_range(0, 99) < 35);
        else           done_r[k] = ($urandom_range(0, 999) < 3);
      end
      drive(rts_r, op_r, prm_r, done_r);
      model_edge(rts_r, op_r, prm_r, done_r);
      step();
      chk($sformatf("rnd%0d start", c),  64'(eng_start_out),  64'(m_start));
      chk($sformatf("rnd%0d params", c), eng_params_out,      m_params);
      chk($sformatf("rnd%0d count", c),  64'(disp_count_out), 64'(m_cnt));
      chk($sformatf("rnd%0d err", c),    64'(err_out),        64'(m_err));
      chk($sformatf("rnd%0d rtr", c),    64'(cmd_rtr_out),    64'(mq.size() < 4));
      chk($sformatf("rnd%0d idle", c),   64'(idle_out),
          64'((mq.size() == 0) && (m_busy == 3'b000)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
